// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the TDM serial-to-parallel demultiplexer.
// The parity slot (TDM_DEMUX_PARITY_EN builds) is appended PAR_SLOT_OFS slots after the data slots.
package tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COLLECT   = 2'd1,
    ST_WAIT_SYNC = 2'd2
  } state_e;

  localparam int NCH_DEFAULT  = 4;
  localparam int PAR_SLOT_OFS = 1;

  // XOR-reduce of the data bits; an even-parity slot must carry this value.
  function automatic logic even_par(input logic [15:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Channel-side bundle of tdm_demux4: serial slot input and parallel word output.
// par_err exists only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux4_if #(
  parameter int NCH  = 4,
`ifdef TDM_DEMUX_PARITY_EN
  parameter int SELW = $clog2(NCH) + 1
`else
  parameter int SELW = $clog2(NCH)
`endif
) ();

  logic            en;
  logic            sync_in;
  logic            din;
  logic [NCH-1:0]  dout;
  logic            valid;
  logic [SELW-1:0] sel_out;
  logic            frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic            par_err;
`endif

  modport slave (
    input  en, sync_in, din,
    output dout, valid, sel_out, frame_err
`ifdef TDM_DEMUX_PARITY_EN
    , output par_err
`endif
  );

  modport master (
    output en, sync_in, din,
    input  dout, valid, sel_out, frame_err
`ifdef TDM_DEMUX_PARITY_EN
    , input par_err
`endif
  );

endinterface

// File: rtl/tdm_demux4_slot_cnt.sv
// Slot counter: clear beats load-to-1 beats increment, all qualified by en_i.
// tc_o flags the last slot of a frame.
module tdm_slot_cnt #(
  parameter int SELW   = 2,
  parameter int TC_VAL = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            load1_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [SELW-1:0] cnt_o,
  output logic            tc_o
);

  localparam logic [SELW-1:0] ONE = {{(SELW-1){1'b0}}, 1'b1};
  localparam logic [SELW-1:0] TC  = SELW'(TC_VAL);

  logic [SELW-1:0] cnt_q;
  logic [SELW-1:0] cnt_d;

  // Next slot value.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = cnt_q;
    end else if (clr_i) begin
      cnt_d = {SELW{1'b0}};
    end else if (load1_i) begin
      cnt_d = ONE;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {SELW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/tdm_demux4.sv
// TDM demultiplexer top: rebuilds the NCH-bit channel word from the serial slot stream.
// Define TDM_DEMUX_PARITY_EN to add a trailing even-parity slot and the par_err pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
`ifdef TDM_DEMUX_PARITY_EN
  parameter int SELW = $clog2(NCH) + 1
`else
  parameter int SELW = $clog2(NCH)
`endif
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int LAST_SLOT = NCH - 1 + PAR_SLOT_OFS;
`else
  localparam int LAST_SLOT = NCH - 1;
`endif

  state_e          state_q, state_d;
  logic [NCH-1:0]  asm_q, asm_d;
  logic [NCH-1:0]  dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic            perr_q, perr_d;
`endif
  logic            cnt_load1, cnt_clr, cnt_inc, cnt_tc;
  logic [SELW-1:0] cnt;
  logic [NCH-1:0]  din_word;
  logic [NCH-1:0]  asm_cur;

  tdm_slot_cnt #(
    .SELW   (SELW),
    .TC_VAL (LAST_SLOT)
  ) u_slot_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (bus.en),
    .load1_i (cnt_load1),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .cnt_o   (cnt),
    .tc_o    (cnt_tc)
  );

  // Unfilled slots are always zero, so OR-ing the shifted bit places it at the current slot.
  assign din_word = {{(NCH-1){1'b0}}, bus.din};
  assign asm_cur  = asm_q | (din_word << cnt);

  // Frame state machine: next state, assembly word and output pulses.
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d    = 1'b0;
`endif
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (bus.en) begin
      case (state_q)
        ST_IDLE, ST_WAIT_SYNC: begin
          if (bus.sync_in) begin
            asm_d     = din_word;
            cnt_load1 = 1'b1;
            state_d   = ST_COLLECT;
          end else if (state_q == ST_WAIT_SYNC) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (bus.sync_in) begin
            ferr_d    = 1'b1;
            asm_d     = din_word;
            cnt_load1 = 1'b1;
          end else if (cnt_tc) begin
`ifdef TDM_DEMUX_PARITY_EN
            if (even_par(16'(asm_q)) == bus.din) begin
              dout_d  = asm_q;
              valid_d = 1'b1;
            end else begin
              perr_d  = 1'b1;
            end
`else
            dout_d  = asm_cur;
            valid_d = 1'b1;
`endif
            asm_d   = {NCH{1'b0}};
            cnt_clr = 1'b1;
            state_d = ST_WAIT_SYNC;
          end else begin
            asm_d   = asm_cur;
            cnt_inc = 1'b1;
          end
        end
        default: begin
          asm_d   = {NCH{1'b0}};
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      asm_q   <= {NCH{1'b0}};
      dout_q  <= {NCH{1'b0}};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.sel_out   = cnt;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err   = perr_q;
`endif

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Serial-to-parallel time-division demultiplexer: receives a 1-bit stream in which a 4:1 mux sequencing `sel` 0..3 has placed one channel bit per slot, and rebuilds the parallel channel word. Sits at the far end of the serial link, after the mux-based serializer, and feeds the parallel word to downstream logic with a one-cycle valid strobe. It detects framing errors against a frame-start marker and, optionally, checks a per-frame parity bit.

## Interface
- `NCH`, 4, number of channels (data slots) per frame; power of two, 2..16
- `SELW`, 2, slot index width, equal to log2(`NCH`)
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  `din`/`sync_in` carry a valid slot this cycle; when low, all state holds
- `sync_in`  in  1  marks slot 0 of a frame; sampled only when `en`=1
- `din`  in  1  serial channel bit
- `dout`  out  NCH  last complete word; bit i holds the value received in slot i
- `valid`  out  1  one-cycle pulse: `dout` was updated on this edge
- `sel_out`  out  SELW  slot index the next accepted bit will fill
- `frame_err`  out  1  one-cycle pulse on a framing violation

## Operation
- Reset values: `dout`=0, `valid`=0, `frame_err`=0, `sel_out`=0, state=IDLE, and the internal assembly register cleared.
- State IDLE. If `en`&`sync_in`: store `din` in assembly bit 0, set slot to 1, go to COLLECT. If `en`&!`sync_in`: discard the bit, no error, stay in IDLE.
- State COLLECT, slot k in 1..NCH-1, when `en`:
  - If `sync_in`=1: this is a resync. Pulse `frame_err`, discard the partial frame, store `din` as bit 0, set slot to 1, stay in COLLECT.
  - Otherwise store `din` at bit k. If k=NCH-1, the frame is complete: load `dout` from the assembly register including the current bit, pulse `valid`, set slot to 0, go to WAIT_SYNC. Otherwise increment slot.
- State WAIT_SYNC (slot 0 expected), when `en`:
  - If `sync_in`=1: behave as the IDLE start.
  - If `sync_in`=0: pulse `frame_err` and go to IDLE.
- `sel_out` always shows the current slot counter. It is 0 in IDLE and WAIT_SYNC.
- `dout` changes only on a completed (and, when enabled, parity-good) frame. Otherwise it holds the previous word.

## Timing
- Registered outputs. The edge that samples the last slot bit also updates `dout` and raises `valid`. Both are visible in the cycle after the last bit is presented.
- Back-to-back frames run with no idle cycles: a full frame every NCH cycles (NCH+1 with parity) while `en`=1.
- `en` low for any number of cycles holds slot, state and the partial word; `valid` and `frame_err` stay 0.
- `valid` and `frame_err` are never both high in the same cycle.
- Reset asserted mid-frame clears everything immediately, independent of the clock. The first frame after reset release needs `sync_in`.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - The frame is NCH+1 slots. Slot NCH carries an even-parity bit over the NCH data bits, and `sel_out` reaches NCH.
  - Output `par_err` (1 bit, reset 0) pulses when parity fails. In that case `dout` holds and `valid` stays 0.
  - The state after the parity slot is WAIT_SYNC in both cases.
  - `SELW` must then be log2(`NCH`)+1.
- Not defined: the frame is NCH slots, there is no `par_err` port, and the slot counter wraps after NCH-1.

## Structure
- `tdm_pkg`: state encoding constants (IDLE, COLLECT, WAIT_SYNC), the default `NCH`, and the parity-slot offset constant.
- One sub-module, `tdm_slot_cnt`: a loadable slot counter with load-to-1, clear, increment on `en`, and a terminal-count flag.

## Test plan
- Reset then frame: `en`=1, slots {sync=1,din=1},{0},{1},{1} → `dout`=4'b1101 with `valid` high for exactly one cycle; `sel_out` reads 0,1,2,3,0.
- Back-to-back frames 4'b1101 then 4'b0010 with no gap → two `valid` pulses 4 cycles apart, `frame_err` never high.
- Resync: `sync_in`=1 again at slot 2 → `frame_err` pulse, `dout` unchanged, new frame bits 1,0,0,0 complete to `dout`=4'b0001.
- Missing sync after a complete frame (slot 0 with `sync_in`=0) → `frame_err` pulse, IDLE, following non-sync bits ignored.
- `en` toggling 1-0-1 within a frame, with `rst` pulsed mid-frame in a second frame → first frame assembles correctly despite the gaps; the reset zeroes all outputs asynchronously.
- With `TDM_DEMUX_PARITY_EN`: data 4'b1101 + parity 1 → `valid`, `dout`=4'b1101; data 4'b1101 + parity 0 → `par_err` pulse, no `valid`, `dout` holds.
